// File: rtl/miner_pkg.sv
// Shared constants and types for the miner job controller and its TX framer.
package miner_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_START  = 3'd2;
    localparam state_t ST_RUN    = 3'd3;
    localparam state_t ST_REPORT = 3'd4;

    localparam logic [7:0] CMD_JOB   = 8'h01;
    localparam logic [7:0] CMD_ABORT = 8'h02;

    localparam logic [7:0] RSP_FOUND     = 8'hA5;
    localparam logic [7:0] RSP_EXHAUSTED = 8'h5A;
    localparam logic [7:0] RSP_ABORTED   = 8'h5B;

    localparam int JOB_BYTES = 52;

    // Field order matches the wire order of the job frame, first byte in the MSBs.
    typedef struct packed {
        logic [255:0] midstate;
        logic [95:0]  work_data;
        logic [31:0]  nonce_min;
        logic [31:0]  nonce_max;
    } job_t;

endpackage

// File: rtl/miner_job_ctrl_if.sv
// Host byte-stream link: valid-only RX bytes in, valid/ready TX bytes out.
interface miner_job_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, output rx_valid, output tx_ready,
                    input  tx_data, input  tx_valid);
    modport slave  (input  rx_data, input  rx_valid, input  tx_ready,
                    output tx_data, output tx_valid);
endinterface

// File: rtl/miner_tx_frame.sv
// Five-byte valid/ready serializer: type byte, then a 32-bit payload MSB first.
module miner_tx_frame (
    input  logic        hash_clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  frame_type,
    input  logic [31:0] payload,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);
    logic [31:0] rest;
    logic [2:0]  idx;

    assign done = tx_valid && tx_ready && (idx == 3'd4);

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            rest     <= '0;
            idx      <= '0;
        end else if (load) begin
            tx_data  <= frame_type;
            tx_valid <= 1'b1;
            rest     <= payload;
            idx      <= '0;
        end else if (tx_valid && tx_ready) begin
            if (idx == 3'd4) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= rest[31:24];
                rest    <= {rest[23:0], 8'h00};
                idx     <= idx + 3'd1;
            end
        end
    end
endmodule

// File: rtl/miner_job_ctrl.sv
// Job controller: loads a host job frame into the miner and reports the outcome.
//   state  | meaning
//   IDLE   | waiting for a new-job command
//   LOAD   | collecting the 52 payload bytes
//   START  | holding miner in reset after load
//   RUN    | miner hashing; watch golden, drain, commands
//   REPORT | sending the 5-byte result frame
module miner_job_ctrl
    import miner_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 160,
    parameter int unsigned RX_TIMEOUT   = 1000000
) (
    input  logic             hash_clk,
    input  logic             reset,
    miner_job_ctrl_if.slave  host,
    output logic [255:0]     midstate,
    output logic [95:0]      work_data,
    output logic [31:0]      nonce_min,
    output logic [31:0]      nonce_max,
    output logic             miner_reset,
    input  logic [31:0]      current_nonce,
    input  logic [31:0]      golden_nonce,
    input  logic             new_golden_nonce,
    output logic             busy
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int IW = $clog2(RX_TIMEOUT + 1);
    localparam logic [7:0]    START_LAST = 8'(RESET_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(RX_TIMEOUT);
    localparam logic [5:0]    BYTE_LAST  = 6'(JOB_BYTES - 1);

    state_t          state, state_n;
    job_t            job_q;
    logic [415:0]    job_sr;
    logic [5:0]      byte_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [7:0]      start_cnt;
    logic            drain_flag;
    logic [DW-1:0]   drain_cnt;
    logic            rsp_load;
    logic [7:0]      rsp_type;
    logic [31:0]     rsp_payload;
    logic            tx_done;
    logic            is_job, is_abort;

    assign is_job    = host.rx_valid && (host.rx_data == CMD_JOB);
    assign is_abort  = host.rx_valid && (host.rx_data == CMD_ABORT);
    assign busy      = (state != ST_IDLE);
    assign midstate  = job_q.midstate;
    assign work_data = job_q.work_data;
    assign nonce_min = job_q.nonce_min;
    assign nonce_max = job_q.nonce_max;

    always_comb begin
        rsp_load    = 1'b0;
        rsp_type    = RSP_FOUND;
        rsp_payload = golden_nonce;
        state_n     = state;
        case (state)
            ST_IDLE:   if (is_job) state_n = ST_LOAD;
            ST_LOAD: begin
                if (host.rx_valid && byte_cnt == BYTE_LAST) state_n = ST_START;
                else if (!host.rx_valid && idle_cnt == IDLE_LAST) state_n = ST_IDLE;
            end
            ST_START:  if (start_cnt == START_LAST) state_n = ST_RUN;
            ST_RUN: begin
                if (new_golden_nonce) begin
                    rsp_load = 1'b1;
                end else if (drain_flag && drain_cnt == DRAIN_LAST) begin
                    rsp_load    = 1'b1;
                    rsp_type    = RSP_EXHAUSTED;
                    rsp_payload = job_q.nonce_max;
                end else if (is_abort) begin
                    rsp_load    = 1'b1;
                    rsp_type    = RSP_ABORTED;
                    rsp_payload = current_nonce;
                end
                if (rsp_load)    state_n = ST_REPORT;
                else if (is_job) state_n = ST_LOAD;
            end
            ST_REPORT: if (tx_done) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // miner_reset follows the next state, so START spans RESET_CYCLES+1 cycles
    // and reset is reasserted in the very cycle RUN is left.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            miner_reset <= 1'b1;
            job_q       <= '0;
            job_sr      <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            start_cnt   <= '0;
            drain_flag  <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            state       <= state_n;
            miner_reset <= (state_n != ST_RUN);
            if (state == ST_LOAD) begin
                if (host.rx_valid) begin
                    job_sr   <= {job_sr[407:0], host.rx_data};
                    byte_cnt <= byte_cnt + 6'd1;
                    idle_cnt <= '0;
                    if (byte_cnt == BYTE_LAST) job_q <= {job_sr[407:0], host.rx_data};
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end else begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end
            start_cnt <= (state == ST_START) ? start_cnt + 8'd1 : 8'd0;
            if (state == ST_RUN && state_n == ST_RUN) begin
                if (drain_flag)                          drain_cnt  <= drain_cnt + DW'(1);
                else if (current_nonce == job_q.nonce_max) drain_flag <= 1'b1;
            end else begin
                drain_flag <= 1'b0;
                drain_cnt  <= '0;
            end
        end
    end

    miner_tx_frame u_tx_frame (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .load       (rsp_load),
        .frame_type (rsp_type),
        .payload    (rsp_payload),
        .tx_ready   (host.tx_ready),
        .tx_data    (host.tx_data),
        .tx_valid   (host.tx_valid),
        .done       (tx_done)
    );
endmodule
